rv32_trap_ctrl: RTL and testbench
=================================

Name: rv32_trap_ctrl

Overview:
Trap sequencer for one hart. It sits between the pipeline and rv32_csr.
- Samples pending and enabled interrupts and synchronous exceptions.
- Drains the pipeline, then pulses the CSR exception-stack update with cause and epc.
- Redirects fetch to the mtvec-derived handler address.
- Also sequences mret: pulses the CSR return, then redirects to mepc.

Parameters:
FLUSH_CYCLES, 4, cycles flush_o is held to drain the pipeline (legal range 1..15).
MVU_IRQ_BIT, 16, mip/mie bit index of the MVU interrupt.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
mip_i  in  32  mip_q from CSR
mie_i  in  32  mie_q from CSR
mstatus_mie_i  in  1  mstatus.mie from CSR
mtvec_i  in  32  mtvec_q from CSR
mepc_i  in  32  mepc_q from CSR
instr_valid_i  in  1  an instruction retires this cycle
instr_pc_i  in  32  PC of the retiring instruction
exc_valid_i  in  1  synchronous exception on the retiring instruction
exc_cause_i  in  5  exception code
mret_i  in  1  retiring instruction is mret
flush_o  out  1  kill all in-flight instructions
trap_we_o  out  1  one-cycle pulse: CSR loads cause/epc and stacks mie
trap_cause_o  out  32  mcause value
trap_epc_o  out  32  mepc value
mret_o  out  1  one-cycle pulse: CSR restores mie from mpie
redirect_valid_o  out  1  new fetch PC valid
redirect_pc_o  out  32  new fetch PC
redirect_ready_i  in  1  fetch accepted the redirect

Behaviour:
- Clock is clk, reset is rst_n; reset is asynchronous and active-low.
- Reset: state IDLE. All outputs 0. Internal last_pc_q = 0, flush counter = 0.
- last_pc_q: loads instr_pc_i + 4 on every instr_valid_i while in IDLE.
- Interrupt eligibility: irq = mip_i & mie_i & {bits 11, 3, 7, MVU_IRQ_BIT}; eligible only when mstatus_mie_i = 1.
- Interrupt priority: MEI(11) > MSI(3) > MTI(7) > MVU.
- Event priority in IDLE, all sampled in the same cycle:
  - exc_valid_i & instr_valid_i wins first.
  - mret_i & instr_valid_i is next.
  - An eligible interrupt is last.
- Exception: cause_q = {27'b0, exc_cause_i}, epc_q = instr_pc_i.
- Interrupt: cause_q = {1'b1, 26'b0, code}.
  - epc_q = instr_pc_i when instr_valid_i is high; that instruction is squashed and not committed.
  - Otherwise epc_q = last_pc_q.
- Trap path, event sampled in cycle N:
  - FLUSH: flush_o = 1 for cycles N+1 .. N+FLUSH_CYCLES.
  - COMMIT: one cycle. trap_we_o = 1, trap_cause_o = cause_q, trap_epc_o = epc_q.
  - REDIRECT: redirect_valid_o = 1.
- Redirect PC:
  - Base is {mtvec_i[31:2], 2'b00}.
  - Vectored mode (mtvec_i[0] = 1) and interrupt: base + 4*code, 32-bit wrap.
  - Otherwise: base.
- mret path:
  - MRET_FLUSH: same flush length as FLUSH.
  - Then one cycle with mret_o = 1.
  - Then REDIRECT with redirect_pc_o = mepc_i.
- REDIRECT handshake:
  - redirect_valid_o and redirect_pc_o stay stable until redirect_ready_i is high.
  - Transfer happens on valid & ready, then return to IDLE.
  - A redirect is never dropped.
- Non-IDLE states: exc_valid_i, mret_i and interrupts are ignored; flushed instructions must not raise events.
- Interrupts are re-evaluated in IDLE only.
  - After trap_we_o, mstatus_mie_i is 0, so nested entry is impossible.
  - After mret_o, a still-pending interrupt is taken on the first IDLE cycle.
- A mid-operation reset aborts any sequence immediately: no trap_we_o/mret_o pulse, redirect dropped.
- trap_cause_o/trap_epc_o hold their last value outside COMMIT; consumers qualify them with trap_we_o.

Optional Feature:
RV32_TRAP_WFI_EN
- With the macro: adds input wfi_i (1 bit), qualified by instr_valid_i, and state WFI.
  - In WFI, flush_o = 1 and the fetch stall holds.
  - Exit when (mip_i & mie_i) over the supported bits is nonzero, regardless of mstatus_mie_i.
  - If mstatus_mie_i = 1: enter the trap path with epc = PC of the wfi + 4.
  - Otherwise: REDIRECT to the wfi PC + 4.
- Without the macro: no wfi_i port; wfi executes as a nop.

Decomposition:
- Package pito_pkg gains:
  - trap_state_e enum: IDLE, FLUSH, COMMIT, MRET_FLUSH, MRET, REDIRECT, WFI.
  - Constants IRQ_PRIO_MASK and CAUSE_INT_BIT = 31.
  - Interrupt code constants 3, 7, 11 and IRQ_MVU_INTR = MVU_IRQ_BIT.
- One sub-module, rv32_irq_prio: combinational priority encoder. Inputs mip/mie/enable; outputs valid and 5-bit code.

Test Plan:
- mtvec = 0x100 (direct), mie = mip = 0x800, mstatus.mie = 1, instr at 0x2000 → flush_o 4 cycles, trap_we_o with cause 0x8000000B and epc 0x2000, redirect_pc_o 0x100.
- mtvec = 0x101 (vectored), MTI pending → redirect_pc_o 0x11C; cause 0x80000007.
- exc_valid_i with cause 2 at PC 0x3004, plus MEI pending in the same cycle → cause 0x00000002, epc 0x3004, redirect 0x100; MEI is not taken until mret.
- mret_i with mepc = 0x3008, redirect_ready_i low for 3 cycles → mret_o single pulse; redirect_valid_o held with 0x3008 for 4 cycles.
- MEI + MTI + MVU pending together → cause 0x8000000B. With mstatus_mie_i = 0 → no flush, no trap.
- rst_n asserted during FLUSH → all outputs 0 immediately; no trap_we_o after release.

Source files
------------

// File: rtl/pito_pkg.sv
// rtl/pito_pkg.sv - shared trap-sequencer types, interrupt codes and helpers
package pito_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    COMMIT,
    MRET_FLUSH,
    MRET,
    REDIRECT,
    WFI
  } trap_state_e;

  localparam int         CAUSE_INT_BIT       = 31;
  localparam logic [4:0] IRQ_M_SOFT          = 5'd3;
  localparam logic [4:0] IRQ_M_TIMER         = 5'd7;
  localparam logic [4:0] IRQ_M_EXT           = 5'd11;
  localparam int         MVU_IRQ_BIT_DEFAULT = 16;
  localparam logic [4:0] IRQ_MVU_INTR        = 5'(MVU_IRQ_BIT_DEFAULT);

  // Supported interrupt lines: MSI(3), MTI(7), MEI(11) plus the MVU line.
  function automatic logic [31:0] irq_mask(input int mvu_bit);
    return 32'h0000_0888 | (32'd1 << mvu_bit);
  endfunction

  localparam logic [31:0] IRQ_PRIO_MASK = irq_mask(MVU_IRQ_BIT_DEFAULT);

  function automatic logic [31:0] irq_cause(input logic [4:0] code);
    return {1'b1, 26'b0, code};
  endfunction

endpackage

// File: rtl/rv32_irq_prio.sv
// rtl/rv32_irq_prio.sv - combinational priority encoder: MEI > MSI > MTI > MVU
module rv32_irq_prio
  import pito_pkg::*;
#(
  parameter int MVU_IRQ_BIT = MVU_IRQ_BIT_DEFAULT
) (
  input  logic [31:0] mip,
  input  logic [31:0] mie,
  input  logic        enable,
  output logic        pending,
  output logic        valid,
  output logic [4:0]  code
);

  logic [31:0] irq;

  always_comb begin
    irq     = mip & mie & irq_mask(MVU_IRQ_BIT);
    pending = |irq;
    valid   = enable & pending;
    if (irq[IRQ_M_EXT])        code = IRQ_M_EXT;
    else if (irq[IRQ_M_SOFT])  code = IRQ_M_SOFT;
    else if (irq[IRQ_M_TIMER]) code = IRQ_M_TIMER;
    else                       code = 5'(MVU_IRQ_BIT);
  end

endmodule

// File: rtl/rv32_trap_ctrl.sv
// rtl/rv32_trap_ctrl.sv - trap/mret sequencer: flush, CSR update pulse, fetch redirect
// Optional wfi support is built with RV32_TRAP_WFI_EN.
module rv32_trap_ctrl
  import pito_pkg::*;
#(
  parameter int FLUSH_CYCLES = 4,
  parameter int MVU_IRQ_BIT  = int'(IRQ_MVU_INTR)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mip_i,
  input  logic [31:0] mie_i,
  input  logic        mstatus_mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_pc_i,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_cause_i,
  input  logic        mret_i,
`ifdef RV32_TRAP_WFI_EN
  input  logic        wfi_i,
`endif
  output logic        flush_o,
  output logic        trap_we_o,
  output logic [31:0] trap_cause_o,
  output logic [31:0] trap_epc_o,
  output logic        mret_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  trap_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] last_pc_q;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] trap_cause_q, trap_cause_d;
  logic [31:0] trap_epc_q, trap_epc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        irq_pending;
  logic        irq_valid;
  logic [4:0]  irq_code;
  logic [31:0] handler_base;
  logic [31:0] handler_pc;
  logic        unused_mtvec_bit1;

  rv32_irq_prio #(
    .MVU_IRQ_BIT(MVU_IRQ_BIT)
  ) u_irq_prio (
    .mip    (mip_i),
    .mie    (mie_i),
    .enable (mstatus_mie_i),
    .pending(irq_pending),
    .valid  (irq_valid),
    .code   (irq_code)
  );

`ifndef RV32_TRAP_WFI_EN
  logic unused_irq_pending;
  assign unused_irq_pending = irq_pending;
`endif

  assign unused_mtvec_bit1 = mtvec_i[1];

  // Vectored mode only offsets asynchronous causes; exceptions always use the base.
  always_comb begin
    handler_base = {mtvec_i[31:2], 2'b00};
    if (mtvec_i[0] && cause_q[CAUSE_INT_BIT])
      handler_pc = handler_base + {25'b0, cause_q[4:0], 2'b00};
    else
      handler_pc = handler_base;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    trap_cause_d  = trap_cause_q;
    trap_epc_d    = trap_epc_q;
    redirect_pc_d = redirect_pc_q;
    unique case (state_q)
      IDLE: begin
        if (instr_valid_i && exc_valid_i) begin
          cause_d = {27'b0, exc_cause_i};
          epc_d   = instr_pc_i;
          cnt_d   = FLUSH_LAST;
          state_d = FLUSH;
        end else if (instr_valid_i && mret_i) begin
          cnt_d   = FLUSH_LAST;
          state_d = MRET_FLUSH;
        end else if (irq_valid) begin
          // A retiring instruction is squashed so the handler returns to it.
          cause_d = irq_cause(irq_code);
          epc_d   = instr_valid_i ? instr_pc_i : last_pc_q;
          cnt_d   = FLUSH_LAST;
          state_d = FLUSH;
`ifdef RV32_TRAP_WFI_EN
        end else if (instr_valid_i && wfi_i) begin
          state_d = WFI;
`endif
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          trap_cause_d = cause_q;
          trap_epc_d   = epc_q;
          state_d      = COMMIT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      COMMIT: begin
        redirect_pc_d = handler_pc;
        state_d       = REDIRECT;
      end
      MRET_FLUSH: begin
        if (cnt_q == 4'd0) state_d = MRET;
        else               cnt_d   = cnt_q - 4'd1;
      end
      MRET: begin
        redirect_pc_d = mepc_i;
        state_d       = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready_i) state_d = IDLE;
      end
      WFI: begin
`ifdef RV32_TRAP_WFI_EN
        // last_pc_q already holds wfi PC + 4 from the cycle the wfi retired.
        if (irq_pending) begin
          if (mstatus_mie_i) begin
            cause_d = irq_cause(irq_code);
            epc_d   = last_pc_q;
            cnt_d   = FLUSH_LAST;
            state_d = FLUSH;
          end else begin
            redirect_pc_d = last_pc_q;
            state_d       = REDIRECT;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      last_pc_q     <= 32'd0;
      cause_q       <= 32'd0;
      epc_q         <= 32'd0;
      trap_cause_q  <= 32'd0;
      trap_epc_q    <= 32'd0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      trap_cause_q  <= trap_cause_d;
      trap_epc_q    <= trap_epc_d;
      redirect_pc_q <= redirect_pc_d;
      if (state_q == IDLE && instr_valid_i) last_pc_q <= instr_pc_i + 32'd4;
    end
  end

  assign flush_o          = (state_q == FLUSH) || (state_q == MRET_FLUSH) || (state_q == WFI);
  assign trap_we_o        = (state_q == COMMIT);
  assign mret_o           = (state_q == MRET);
  assign redirect_valid_o = (state_q == REDIRECT);
  assign trap_cause_o     = trap_cause_q;
  assign trap_epc_o       = trap_epc_q;
  assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_rv32_trap_ctrl.sv
// tb/tb_rv32_trap_ctrl.sv - scoreboard bench for rv32_trap_ctrl with a CSR-side reference model
module tb_rv32_trap_ctrl;

  localparam int FLUSH_CYCLES = 4;
  localparam int MVU_BIT      = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mip_i = '0, mie_i = '0, mtvec_i = '0, mepc_i = '0, instr_pc_i = '0;
  logic        mstatus_mie_i = 1'b0, instr_valid_i = 1'b0, exc_valid_i = 1'b0, mret_i = 1'b0;
  logic [4:0]  exc_cause_i = '0;
  logic        redirect_ready_i = 1'b0;
  logic        flush_o, trap_we_o, mret_o, redirect_valid_o;
  logic [31:0] trap_cause_o, trap_epc_o, redirect_pc_o;

  always #5 clk = ~clk;

  rv32_trap_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .MVU_IRQ_BIT(MVU_BIT)) dut (
    .clk(clk), .rst_n(rst_n), .mip_i(mip_i), .mie_i(mie_i), .mstatus_mie_i(mstatus_mie_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .instr_valid_i(instr_valid_i), .instr_pc_i(instr_pc_i),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .mret_i(mret_i),
`ifdef RV32_TRAP_WFI_EN
    .wfi_i(1'b0),
`endif
    .flush_o(flush_o), .trap_we_o(trap_we_o), .trap_cause_o(trap_cause_o), .trap_epc_o(trap_epc_o),
    .mret_o(mret_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .redirect_ready_i(redirect_ready_i)
  );

  typedef struct {
    bit          is_mret;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_off = 1'b0;
  int   rv_cycles;

  logic [31:0] m_last_pc = '0;
  bit          m_mie = 1'b0;
  bit          m_mpie = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit irq_pick(input logic [31:0] pend, output logic [4:0] code);
    int prio[4] = '{11, 3, 7, MVU_BIT};
    code = 5'd0;
    foreach (prio[i]) if (pend[prio[i]]) begin
      code = 5'(prio[i]);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] handler(input logic [31:0] tvec, input bit is_irq, input logic [4:0] code);
    logic [31:0] base = tvec & ~32'h3;
    return (tvec[0] && is_irq) ? base + 32'(code) * 4 : base;
  endfunction

  function automatic exp_t mk_irq(input logic [4:0] code, input logic [31:0] epc);
    exp_t e;
    e.is_mret = 1'b0;
    e.cause   = 32'h8000_0000 | 32'(code);
    e.epc     = epc;
    e.pc      = handler(mtvec_i, 1'b1, code);
    return e;
  endfunction

  // One retirement cycle plus everything it triggers; returns once the DUT is back in IDLE.
  task automatic issue(input bit iv, input logic [31:0] pc, input bit exc, input logic [4:0] ecause,
                       input bit mr, input int rdy_delay);
    exp_t e;
    logic [4:0] code;
    bit pend;
    pend = irq_pick(mip_i & mie_i, code);
    if (iv && exc) begin
      e.is_mret = 1'b0; e.cause = {27'b0, ecause}; e.epc = pc; e.pc = handler(mtvec_i, 1'b0, 5'd0);
      exp_q.push_back(e);
    end else if (iv && mr) begin
      e.is_mret = 1'b1; e.cause = '0; e.epc = '0; e.pc = mepc_i;
      exp_q.push_back(e);
      if (m_mpie && pend) exp_q.push_back(mk_irq(code, pc + 32'd4));
    end else if (m_mie && pend) begin
      exp_q.push_back(mk_irq(code, iv ? pc : m_last_pc));
    end
    if (iv) m_last_pc = pc + 32'd4;
    mstatus_mie_i = m_mie;
    instr_valid_i = iv; instr_pc_i = pc; exc_valid_i = exc; exc_cause_i = ecause; mret_i = mr;
    @(posedge clk); #1;
    instr_valid_i = 1'b0; exc_valid_i = 1'b0; mret_i = 1'b0;
    rv_cycles = 0;
    for (int cyc = 0; exp_q.size() != 0; cyc++) begin
      if (cyc > 200) begin
        chk("sequence_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        break;
      end
      if (trap_we_o) begin m_mpie = m_mie; m_mie = 1'b0; end
      if (mret_o)    begin m_mie = m_mpie; m_mpie = 1'b1; end
      mstatus_mie_i = m_mie;
      if (redirect_valid_o) begin
        redirect_ready_i = (rdy_delay < 0) ? 1'($urandom_range(0, 1)) : (rv_cycles >= rdy_delay);
        rv_cycles++;
      end else begin
        redirect_ready_i = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin : monitor
    int fl = 0;
    int pulses = 0;
    bit held = 1'b0;
    logic [31:0] held_pc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || mon_off) begin
        fl = 0; pulses = 0; held = 1'b0;
      end else if (exp_q.size() == 0) begin
        chk("idle_quiet", {28'b0, flush_o, trap_we_o, mret_o, redirect_valid_o}, 32'd0);
      end else begin
        if (flush_o) fl++;
        if (trap_we_o) begin
          chk("trap_kind", 32'(exp_q[0].is_mret), 32'd0);
          chk("trap_cause", trap_cause_o, exp_q[0].cause);
          chk("trap_epc", trap_epc_o, exp_q[0].epc);
          chk("trap_flush_len", 32'(fl), 32'(FLUSH_CYCLES));
          fl = 0; pulses++;
        end
        if (mret_o) begin
          chk("mret_kind", 32'(exp_q[0].is_mret), 32'd1);
          chk("mret_flush_len", 32'(fl), 32'(FLUSH_CYCLES));
          fl = 0; pulses++;
        end
        if (redirect_valid_o) begin
          if (held) chk("redirect_stable", redirect_pc_o, held_pc);
          if (redirect_ready_i) begin
            chk("redirect_pc", redirect_pc_o, exp_q[0].pc);
            chk("pulse_count", 32'(pulses), 32'd1);
            void'(exp_q.pop_front());
            held = 1'b0; pulses = 0; fl = 0;
          end else begin
            held = 1'b1; held_pc = redirect_pc_o;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_trap_we", 32'(trap_we_o), 32'd0);
    chk("rst_mret", 32'(mret_o), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid_o), 32'd0);
    chk("rst_redirect_pc", redirect_pc_o, 32'd0);
    chk("rst_trap_cause", trap_cause_o, 32'd0);
    chk("rst_trap_epc", trap_epc_o, 32'd0);
    rst_n = 1'b1;

    // Direct-mode MEI on a retiring instruction.
    mtvec_i = 32'h100; mip_i = 32'h800; mie_i = 32'h800; m_mie = 1'b1;
    issue(1'b1, 32'h2000, 1'b0, 5'd0, 1'b0, -1);

    // Vectored MTI.
    mtvec_i = 32'h101; mip_i = 32'h80; mie_i = 32'h80; m_mie = 1'b1;
    issue(1'b1, 32'h2100, 1'b0, 5'd0, 1'b0, -1);

    // Exception beats a simultaneous MEI; MEI waits until after mret.
    mtvec_i = 32'h100; mip_i = 32'h800; mie_i = 32'h800; m_mie = 1'b1;
    issue(1'b1, 32'h3004, 1'b1, 5'd2, 1'b0, -1);
    for (int i = 0; i < 3; i++) issue(1'b1, 32'h3100 + 32'(i * 4), 1'b0, 5'd0, 1'b0, -1);
    mepc_i = 32'h3008;
    issue(1'b1, 32'h0500, 1'b0, 5'd0, 1'b1, -1);

    // mret with redirect back-pressure.
    mip_i = 32'h0; m_mpie = 1'b1;
    issue(1'b1, 32'h0600, 1'b0, 5'd0, 1'b1, 3);
    chk("mret_redirect_cycles", 32'(rv_cycles), 32'd4);

    // Priority among several pending lines, then global disable.
    mtvec_i = 32'h100; mip_i = 32'h10880; mie_i = 32'h10880; m_mie = 1'b1;
    issue(1'b1, 32'h4000, 1'b0, 5'd0, 1'b0, -1);
    m_mie = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b1, 32'h4100 + 32'(i * 4), 1'b0, 5'd0, 1'b0, -1);

    // Reset in the middle of FLUSH.
    mon_off = 1'b1;
    mstatus_mie_i = 1'b1; instr_valid_i = 1'b1; instr_pc_i = 32'h5000;
    @(posedge clk); #1;
    instr_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_flush", 32'(flush_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_flush", 32'(flush_o), 32'd0);
    chk("midrst_trap_we", 32'(trap_we_o), 32'd0);
    chk("midrst_redirect_valid", 32'(redirect_valid_o), 32'd0);
    chk("midrst_trap_cause", trap_cause_o, 32'd0);
    m_mie = 1'b0; m_mpie = 1'b0; m_last_pc = '0; mstatus_mie_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_off = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, -1);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      mip_i   = $urandom & $urandom;
      mie_i   = $urandom;
      mtvec_i = $urandom;
      mepc_i  = $urandom;
      if ($urandom_range(0, 3) == 0) m_mie = 1'($urandom_range(0, 1));
      issue(1'($urandom_range(0, 1)), $urandom & ~32'h3, ($urandom_range(0, 4) == 0),
            5'($urandom_range(0, 31)), ($urandom_range(0, 4) == 0), -1);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
